// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshakes, trap handling (illegal, ecall, ebreak, memory timeout) and a debug HALT state.
module multicycle_control_fsm #(
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [11:0] funct12,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        resume,
  output logic        imem_req,
  output logic        ir_write,
  output logic        en_pc,
  output logic        RegWrite,
  output logic        AluSrc,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic [1:0]  sel_data_to_reg,
  output logic [1:0]  Alu_op,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        halted,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CL_WB    = 2'd0,
    CL_LOAD  = 2'd1,
    CL_STORE = 2'd2,
    CL_NOWB  = 2'd3
  } class_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  class_t                 cls_q, cls_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   alusrc_q, alusrc_d;
  logic [1:0]             sel_q, sel_d;
  logic [1:0]             aluop_q, aluop_d;
  logic [1:0]             cause_q, cause_d;

  logic unused_funct12;
  assign unused_funct12 = ^funct12[11:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cls_q    <= CL_NOWB;
      cnt_q    <= '0;
      alusrc_q <= 1'b0;
      sel_q    <= 2'b00;
      aluop_q  <= 2'b00;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      cnt_q    <= cnt_d;
      alusrc_q <= alusrc_d;
      sel_q    <= sel_d;
      aluop_q  <= aluop_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = '0;  // only meaningful while waiting; any entry to FETCH/MEM starts at zero
    alusrc_d  = alusrc_q;
    sel_d     = sel_q;
    aluop_d   = aluop_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    en_pc     = 1'b0;
    RegWrite  = 1'b0;
    Mem_read  = 1'b0;
    Mem_write = 1'b0;
    trap      = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == TO_LAST) begin
          cause_d = 2'b11;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        alusrc_d = 1'b0;
        sel_d    = 2'b00;
        aluop_d  = 2'b00;
        cls_d    = CL_NOWB;
        state_d  = S_EXEC;
        case (opcode)
          7'b0110011: begin alusrc_d = 1'b1; sel_d = 2'b01; aluop_d = 2'b01; cls_d = CL_WB; end
          7'b0010011: begin sel_d = 2'b01; aluop_d = 2'b10; cls_d = CL_WB; end
          7'b0000011: cls_d = CL_LOAD;
          7'b0100011: cls_d = CL_STORE;
          7'b1100011: aluop_d = 2'b11;
          7'b1101111,
          7'b1100111: begin sel_d = 2'b10; aluop_d = 2'b11; cls_d = CL_WB; end
          7'b0110111,
          7'b0010111: begin sel_d = 2'b11; aluop_d = 2'b11; cls_d = CL_WB; end
          7'b0001111: aluop_d = 2'b11;
          7'b1110011: begin
            aluop_d = 2'b11;
            cause_d = funct12[0] ? 2'b10 : 2'b01;
            state_d = S_TRAP;
          end
          default: begin
            cause_d = 2'b00;
            state_d = S_TRAP;
          end
        endcase
      end

      S_EXEC: begin
        case (cls_q)
          CL_LOAD, CL_STORE: state_d = S_MEM;
          CL_NOWB: begin
            en_pc   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        Mem_read  = (cls_q == CL_LOAD);
        Mem_write = (cls_q == CL_STORE);
        if (dmem_ready) begin
          if (cls_q == CL_LOAD) begin
            state_d = S_WB;
          end else begin
            en_pc   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == TO_LAST) begin
          cause_d = 2'b11;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        en_pc    = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
        if (cause_q == 2'b11 || (cause_q == 2'b10 && HALT_ON_EBREAK)) begin
          state_d = S_HALT;
        end else begin
          en_pc   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          // a timed-out access is retried, so the PC must not move
          en_pc   = (cause_q != 2'b11);
          state_d = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase

    // FETCH is the reset state, so its request must be masked while reset is held
    if (reset) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      en_pc     = 1'b0;
      RegWrite  = 1'b0;
      Mem_read  = 1'b0;
      Mem_write = 1'b0;
      trap      = 1'b0;
      halted    = 1'b0;
    end
  end

  assign AluSrc          = alusrc_q;
  assign sel_data_to_reg = sel_q;
  assign Alu_op          = aluop_q;
  assign trap_cause      = cause_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: instruction flows, traps, halt/resume,
// memory timeout (TIMEOUT_CYCLES=4) and asynchronous reset mid-access.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [11:0] funct12;
  logic        imem_ready, dmem_ready, resume;
  logic        imem_req, ir_write, en_pc, RegWrite, AluSrc, Mem_read, Mem_write;
  logic [1:0]  sel_data_to_reg, Alu_op, trap_cause;
  logic        trap, halted;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int n_cyc = 0, n_enpc = 0, n_regw = 0, n_memr = 0, n_memw = 0, n_trap = 0;
  int b_cyc, b_enpc, b_regw, b_memr, b_memw, b_trap;

  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011, OP_SYS = 7'b1110011;

  multicycle_control_fsm #(.TIMEOUT_W(8), .TIMEOUT_CYCLES(4), .HALT_ON_EBREAK(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct12(funct12),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
    .imem_req(imem_req), .ir_write(ir_write), .en_pc(en_pc), .RegWrite(RegWrite),
    .AluSrc(AluSrc), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .sel_data_to_reg(sel_data_to_reg), .Alu_op(Alu_op), .trap(trap),
    .trap_cause(trap_cause), .halted(halted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_cyc++;
    if (en_pc) n_enpc++;
    if (RegWrite) n_regw++;
    if (Mem_read) n_memr++;
    if (Mem_write) n_memw++;
    if (trap) n_trap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_cyc = n_cyc; b_enpc = n_enpc; b_regw = n_regw;
    b_memr = n_memr; b_memw = n_memw; b_trap = n_trap;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'h00; funct12 = 12'h000;
    imem_ready = 1'b0; dmem_ready = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_en_pc", 32'(en_pc), 0);
    chk("rst_cause", 32'(trap_cause), 0);
    chk("rst_halted", 32'(halted), 0);

    // R-type add, both memories ready
    reset = 1'b0; opcode = OP_R; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1; snap();
    chk("r_fetch_state", 32'(state_o), 0);
    chk("r_fetch_req", 32'(imem_req), 1);
    chk("r_fetch_irw", 32'(ir_write), 1);
    step(); chk("r_dec_state", 32'(state_o), 1);
    chk("r_dec_regw", 32'(RegWrite), 0);
    step(); chk("r_exec_state", 32'(state_o), 2);
    chk("r_exec_ctl", {29'd0, AluSrc, sel_data_to_reg} , 32'b101);
    chk("r_exec_aluop", 32'(Alu_op), 1);
    chk("r_exec_enpc", 32'(en_pc), 0);
    step(); chk("r_wb_state", 32'(state_o), 4);
    chk("r_wb_regw", 32'(RegWrite), 1);
    chk("r_wb_enpc", 32'(en_pc), 1);
    step(); chk("r_back_fetch", 32'(state_o), 0);
    chk("r_cycles", 32'(n_cyc - b_cyc), 4);
    chk("r_enpc_cnt", 32'(n_enpc - b_enpc), 1);
    chk("r_regw_cnt", 32'(n_regw - b_regw), 1);

    // lw with dmem_ready delayed 3 cycles
    opcode = OP_LD; dmem_ready = 1'b0;
    step(); snap();
    chk("lw_dec_state", 32'(state_o), 1);
    step(); chk("lw_exec_ctl", {27'd0, AluSrc, sel_data_to_reg, Alu_op}, 0);
    chk("lw_exec_mrd", 32'(Mem_read), 0);
    step(); chk("lw_mem_state", 32'(state_o), 3);
    chk("lw_mem_rd1", 32'(Mem_read), 1);
    step(); chk("lw_mem_rd2", 32'(Mem_read), 1);
    step(); chk("lw_mem_rd3", 32'(Mem_read), 1);
    step(); dmem_ready = 1'b1; #1;
    chk("lw_mem_rd4", 32'(Mem_read), 1);
    step(); dmem_ready = 1'b0; #1;
    chk("lw_wb_state", 32'(state_o), 4);
    chk("lw_wb_regw", 32'(RegWrite), 1);
    chk("lw_wb_sel", 32'(sel_data_to_reg), 0);
    step(); chk("lw_back_fetch", 32'(state_o), 0);
    chk("lw_cycles", 32'(n_cyc - b_cyc), 7);
    chk("lw_memrd_cnt", 32'(n_memr - b_memr), 4);
    chk("lw_enpc_cnt", 32'(n_enpc - b_enpc), 1);
    chk("lw_memwr_cnt", 32'(n_memw - b_memw), 0);

    // ecall: trap cause 01, skip instruction
    opcode = OP_SYS; funct12 = 12'h000; #1; snap();
    step(); chk("ecall_dec", 32'(state_o), 1);
    step(); chk("ecall_trap_state", 32'(state_o), 5);
    chk("ecall_trap", 32'(trap), 1);
    chk("ecall_cause", 32'(trap_cause), 1);
    chk("ecall_enpc", 32'(en_pc), 1);
    step(); chk("ecall_fetch", 32'(state_o), 0);

    // illegal opcode 7F
    opcode = 7'h7F; #1; snap();
    step(); chk("ill_dec", 32'(state_o), 1);
    step(); chk("ill_trap", 32'(trap), 1);
    chk("ill_cause", 32'(trap_cause), 0);
    chk("ill_enpc", 32'(en_pc), 1);
    step(); chk("ill_fetch", 32'(state_o), 0);
    chk("ill_regw_cnt", 32'(n_regw - b_regw), 0);
    chk("ill_trap_cnt", 32'(n_trap - b_trap), 1);

    // ebreak halts until resume
    opcode = OP_SYS; funct12 = 12'h001; #1;
    step(); step();
    chk("ebrk_trap", 32'(trap), 1);
    chk("ebrk_cause", 32'(trap_cause), 2);
    chk("ebrk_enpc", 32'(en_pc), 0);
    step(); chk("ebrk_halt_state", 32'(state_o), 6);
    chk("ebrk_halted", 32'(halted), 1);
    chk("ebrk_req", 32'(imem_req), 0);
    step(); step(); chk("ebrk_still_halted", 32'(halted), 1);
    resume = 1'b1; #1;
    chk("ebrk_resume_enpc", 32'(en_pc), 1);
    step(); resume = 1'b0; #1;
    chk("ebrk_resumed_state", 32'(state_o), 0);
    chk("ebrk_unhalted", 32'(halted), 0);

    // instruction fetch timeout after 4 wait cycles
    imem_ready = 1'b0; opcode = OP_R; #1; snap();
    chk("to_req1", 32'(imem_req), 1);
    step(); step(); step();
    chk("to_wait4_state", 32'(state_o), 0);
    chk("to_wait4_req", 32'(imem_req), 1);
    step(); chk("to_trap_state", 32'(state_o), 5);
    chk("to_cause", 32'(trap_cause), 3);
    chk("to_req_dropped", 32'(imem_req), 0);
    step(); chk("to_halt", 32'(halted), 1);
    resume = 1'b1; #1;
    chk("to_resume_enpc", 32'(en_pc), 0);
    step(); resume = 1'b0; #1;
    chk("to_retry_state", 32'(state_o), 0);
    chk("to_enpc_cnt", 32'(n_enpc - b_enpc), 0);

    // ready arriving on the limit cycle wins
    snap();
    step(); step(); step(); imem_ready = 1'b1; #1;
    chk("lim_irw", 32'(ir_write), 1);
    step(); chk("lim_decode", 32'(state_o), 1);
    chk("lim_no_trap", 32'(n_trap - b_trap), 0);
    step(); step(); step();
    chk("lim_done_fetch", 32'(state_o), 0);

    // branch: en_pc from EXEC
    opcode = OP_B; #1;
    step(); step();
    chk("br_exec_enpc", 32'(en_pc), 1);
    chk("br_exec_aluop", 32'(Alu_op), 3);
    chk("br_exec_regw", 32'(RegWrite), 0);
    step(); chk("br_fetch", 32'(state_o), 0);

    // sw aborted by reset in MEM
    opcode = OP_ST; dmem_ready = 1'b0; #1;
    step(); step();
    chk("sw_exec_ctl", {27'd0, AluSrc, sel_data_to_reg, Alu_op}, 0);
    step(); chk("sw_mem_wr", 32'(Mem_write), 1);
    chk("sw_mem_rd", 32'(Mem_read), 0);
    step(); snap();
    reset = 1'b1; #1;
    chk("sw_rst_wr_drop", 32'(Mem_write), 0);
    chk("sw_rst_state", 32'(state_o), 0);
    step(); reset = 1'b0; imem_ready = 1'b0; #1;
    chk("sw_rel_state", 32'(state_o), 0);
    step(); step();
    chk("sw_no_enpc", 32'(n_enpc - b_enpc), 0);
    chk("sw_no_more_wr", 32'(n_memw - b_memw), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
